// File: rtl/alu_sequencer.sv
// alu_sequencer: shares one 32-bit ALU between two requesters with round-robin arbitration,
// per-opcode EXEC latency (multicycle multiply) and a registered valid/ready response.
module alu_sequencer #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic        carry_q
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_SAR  = 4'd9;
  localparam logic [3:0] OP_REV  = 4'd10;
  localparam logic [3:0] OP_MULL = 4'd11;
  localparam logic [3:0] OP_MULH = 4'd12;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] x_q, x_d, y_q, y_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] res_q, res_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;
  logic        carry_d;

  logic        grant_s, hs_s;
  logic [3:0]  sel_op_s;
  logic [32:0] sum_s, diff_s;
  logic [63:0] prod_s;
  logic [31:0] rev_s, alu_r_s;
  logic        alu_c_s, alu_v_s, alu_err_s, alu_arith_s;
  logic [3:0]  alu_flags_s;

  // Grant: a lone requester wins; on a tie the one not granted last wins.
  assign grant_s    = (req0_valid && !req1_valid) ? 1'b0 :
                      (req1_valid && !req0_valid) ? 1'b1 : !last_q;
  assign req0_ready = !rst && (state_q == S_IDLE) && !grant_s;
  assign req1_ready = !rst && (state_q == S_IDLE) && grant_s;
  assign hs_s       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign sel_op_s   = grant_s ? req1_op : req0_op;

  assign rsp_valid  = (state_q == S_DONE);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;

  // ALU datapath, fed only from the latched operands.
  always_comb begin
    sum_s  = {1'b0, x_q} + {1'b0, y_q} + {32'd0, (op_q == OP_ADC) && carry_q};
    diff_s = {1'b0, x_q} - {1'b0, y_q};
    prod_s = {32'd0, x_q} * {32'd0, y_q};
    for (int i = 0; i < 32; i++) rev_s[i] = x_q[31-i];
    alu_r_s     = 32'd0;
    alu_c_s     = 1'b0;
    alu_v_s     = 1'b0;
    alu_err_s   = 1'b0;
    alu_arith_s = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        alu_r_s     = sum_s[31:0];
        alu_c_s     = sum_s[32];
        alu_v_s     = (x_q[31] == y_q[31]) && (sum_s[31] != x_q[31]);
        alu_arith_s = 1'b1;
      end
      OP_SUB: begin
        alu_r_s     = diff_s[31:0];
        alu_c_s     = diff_s[32];
        alu_v_s     = (x_q[31] != y_q[31]) && (diff_s[31] != x_q[31]);
        alu_arith_s = 1'b1;
      end
      OP_AND:  alu_r_s = x_q & y_q;
      OP_OR:   alu_r_s = x_q | y_q;
      OP_XOR:  alu_r_s = x_q ^ y_q;
      OP_NOT:  alu_r_s = ~x_q;
      OP_SHL:  alu_r_s = x_q << y_q[4:0];
      OP_SHR:  alu_r_s = x_q >> y_q[4:0];
      OP_SAR:  alu_r_s = $unsigned($signed(x_q) >>> y_q[4:0]);
      OP_REV:  alu_r_s = rev_s;
      OP_MULL: alu_r_s = prod_s[31:0];
      OP_MULH: alu_r_s = prod_s[63:32];
      default: alu_err_s = 1'b1;
    endcase
    alu_flags_s = alu_err_s ? 4'd0 : {alu_r_s == 32'd0, alu_r_s[31], alu_c_s, alu_v_s};
  end

  // Sequencer next-state: accept in IDLE, count down in EXEC, hold response in DONE.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    rsp_id_d = rsp_id_q;
    res_d    = res_q;
    flags_d  = flags_q;
    err_d    = err_q;
    carry_d  = carry_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          last_d  = grant_s;
          id_d    = grant_s;
          op_d    = sel_op_s;
          x_d     = grant_s ? req1_x : req0_x;
          y_d     = grant_s ? req1_y : req0_y;
          cnt_d   = (sel_op_s == OP_MULL || sel_op_s == OP_MULH) ? MUL_CNT : 4'd1;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd1) begin
          rsp_id_d = id_q;
          res_d    = alu_r_s;
          flags_d  = alu_flags_s;
          err_d    = alu_err_s;
          carry_d  = alu_arith_s ? alu_c_s : carry_q;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and response registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      op_q     <= 4'd0;
      x_q      <= 32'd0;
      y_q      <= 32'd0;
      id_q     <= 1'b0;
      cnt_q    <= 4'd0;
      rsp_id_q <= 1'b0;
      res_q    <= 32'd0;
      flags_q  <= 4'd0;
      err_q    <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      id_q     <= id_d;
      cnt_q    <= cnt_d;
      rsp_id_q <= rsp_id_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
      carry_q  <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: transaction-level reference model checked every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_alu_sequencer;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1, rr;
  logic [3:0]  op0, op1;
  logic [31:0] x0, y0, x1, y1;
  logic        rsp_valid, rsp_id, rsp_err, carry_q;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  alu_sequencer #(.MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_op(op0), .req0_x(x0), .req0_y(y0),
    .req1_valid(v1), .req1_ready(r1), .req1_op(op1), .req1_x(x1), .req1_y(y1),
    .rsp_valid(rsp_valid), .rsp_ready(rr), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .carry_q(carry_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: one transaction in flight, response visible after a cycle countdown
  bit          m_last, m_carry, m_busy, m_vis, m_id, m_err, m_cupd, m_cnew;
  int          m_wait;
  logic [31:0] m_res;
  logic [3:0]  m_flags;

  // values sampled by tick()
  bit          last_hs, last_hs_id, s_valid, s_id, s_err, s_r0, s_r1;
  logic [31:0] s_res;
  logic [3:0]  s_flags;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                  input bit cin, output logic [31:0] r, output logic [3:0] f,
                                  output bit err, output bit cupd);
    logic [32:0] s;
    logic [63:0] p;
    longint      sv, ci;
    int          sh;
    bit          c, v;
    sh = int'(y[4:0]);
    c = 0; v = 0; err = 0; cupd = 0; r = 32'd0;
    ci = (op == 4'd1 && cin) ? 64'sd1 : 64'sd0;
    case (op)
      4'd0, 4'd1: begin
        s  = 33'(x) + 33'(y) + 33'(ci);
        r  = s[31:0]; c = s[32];
        sv = longint'($signed(x)) + longint'($signed(y)) + ci;
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        cupd = 1;
      end
      4'd2: begin
        r  = x - y; c = (x < y);
        sv = longint'($signed(x)) - longint'($signed(y));
        v  = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        cupd = 1;
      end
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: r = ~x;
      4'd7: r = x << sh;
      4'd8: r = x >> sh;
      4'd9: r = $signed(x) >>> sh;
      4'd10: for (int i = 0; i < 32; i++) r[i] = x[31-i];
      4'd11: begin p = 64'(x) * 64'(y); r = p[31:0]; end
      4'd12: begin p = 64'(x) * 64'(y); r = p[63:32]; end
      default: err = 1;
    endcase
    f = err ? 4'd0 : {r == 32'd0, r[31], c, v};
  endfunction

  task automatic model_reset();
    m_last = 1; m_carry = 0; m_busy = 0; m_vis = 0; m_wait = 0;
  endtask

  // One cycle: check DUT against model, then advance the model; starts and ends at negedge.
  task automatic tick();
    bit g, er0, er1;
    logic [3:0] sop;
    #1;
    g   = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : !m_last;
    er0 = !m_busy && !g;
    er1 = !m_busy && g;
    chk("req0_ready", r0, er0);
    chk("req1_ready", r1, er1);
    chk("rsp_valid", rsp_valid, m_vis);
    chk("carry_q", carry_q, m_carry);
    if (m_vis) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_flags", rsp_flags, m_flags);
      chk("rsp_err", rsp_err, m_err);
    end
    s_valid = rsp_valid; s_id = rsp_id; s_res = rsp_result; s_flags = rsp_flags;
    s_err = rsp_err; s_r0 = r0; s_r1 = r1;
    last_hs = 0;
    if (m_vis) begin
      if (rr) begin m_vis = 0; m_busy = 0; end
    end else if (m_busy) begin
      m_wait--;
      if (m_wait == 0) begin
        m_vis = 1;
        if (m_cupd) m_carry = m_cnew;
      end
    end else if ((er0 && v0) || (er1 && v1)) begin
      last_hs = 1; last_hs_id = er1;
      m_id = er1; m_last = er1; m_busy = 1;
      sop = er1 ? op1 : op0;
      if (er1) ref_alu(op1, x1, y1, m_carry, m_res, m_flags, m_err, m_cupd);
      else     ref_alu(op0, x0, y0, m_carry, m_res, m_flags, m_err, m_cupd);
      m_cnew = m_flags[1];
      m_wait = (sop == 4'd11 || sop == 4'd12) ? LAT : 1;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input bit port, input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [3:0] ef, input bit ee, input int elat,
                        input string nm);
    bit got;
    int lat;
    v0 = !port; v1 = port; rr = 1;
    if (port) begin op1 = op; x1 = x; y1 = y; end
    else      begin op0 = op; x0 = x; y0 = y; end
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); got = last_hs; end
    chk({nm, "_accepted"}, got, 1'b1);
    v0 = 0; v1 = 0;
    op0 = 4'($urandom); op1 = 4'($urandom); x0 = $urandom; y0 = $urandom; x1 = $urandom; y1 = $urandom;
    lat = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (s_valid) begin lat = n; break; end
    end
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_result"}, s_res, er);
    chk({nm, "_flags"}, s_flags, ef);
    chk({nm, "_err"}, s_err, ee);
    chk({nm, "_id"}, s_id, port);
  endtask

  logic [31:0] pr;
  logic [3:0]  pf;
  bit          pe, pc;
  logic [31:0] hold_res;
  bit          hold_id, got;
  int          nacc;
  int          ids[4];
  logic [31:0] corner[6] = '{32'h0, 32'hffffffff, 32'h80000000, 32'h7fffffff, 32'h1, 32'h55aa00ff};

  initial begin
    rst = 1; v0 = 1; v1 = 0; rr = 0;
    op0 = 4'd0; op1 = 4'd0; x0 = 32'd0; y0 = 32'd0; x1 = 32'd0; y1 = 32'd0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_req0_ready", r0, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_flags", rsp_flags, 4'd0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_carry", carry_q, 1'b0);
    rst = 0; v0 = 0;

    // pin the reference model with hand-computed values
    ref_alu(4'd0, 32'hffffffff, 32'hffffffff, 1'b0, pr, pf, pe, pc);
    chk("model_add_r", pr, 32'hfffffffe); chk("model_add_f", pf, 4'b0110);
    ref_alu(4'd2, 32'h80000000, 32'h1, 1'b0, pr, pf, pe, pc);
    chk("model_sub_r", pr, 32'h7fffffff); chk("model_sub_f", pf, 4'b0001);
    ref_alu(4'd1, 32'h7fffffff, 32'h0, 1'b1, pr, pf, pe, pc);
    chk("model_adc_r", pr, 32'h80000000); chk("model_adc_f", pf, 4'b0101);

    run_op(0, 4'd0,  32'd2,        32'd6,        32'd8,        4'b0000, 0, 2, "add");
    run_op(0, 4'd0,  32'hffffffff, 32'hffffffff, 32'hfffffffe, 4'b0110, 0, 2, "add_c");
    chk("carry_after_add", carry_q, 1'b1);
    run_op(1, 4'd1,  32'd2,        32'd6,        32'd9,        4'b0000, 0, 2, "adc");
    chk("carry_after_adc", carry_q, 1'b0);
    run_op(0, 4'd12, 32'h7fffffff, 32'h7fffffff, 32'h3fffffff, 4'b0000, 0, LAT + 1, "mulh");
    run_op(1, 4'd11, 32'h7fffffff, 32'h7fffffff, 32'h00000001, 4'b0000, 0, LAT + 1, "mull");
    run_op(0, 4'd2,  32'd10,       32'hffffffec, 32'd30,       4'b0010, 0, 2, "sub");
    run_op(1, 4'd9,  32'h80000301, 32'd2,        32'he00000c0, 4'b0100, 0, 2, "sar");
    run_op(0, 4'd8,  32'h80000301, 32'd2,        32'h200000c0, 4'b0000, 0, 2, "shr");
    run_op(1, 4'd10, 32'hf0aa137f, 32'd0,        32'hfec8550f, 4'b0100, 0, 2, "rev");
    run_op(0, 4'd13, 32'd5,        32'd7,        32'd0,        4'b0000, 1, 2, "illegal");
    chk("carry_after_illegal", carry_q, 1'b1);

    // reset in the middle of a MULH
    run_op(0, 4'd0, 32'hffffffff, 32'd1, 32'd0, 4'b1010, 0, 2, "add_wrap");
    v0 = 1; op0 = 4'd12; x0 = 32'h7fffffff; y0 = 32'h7fffffff; rr = 1;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); got = last_hs; end
    chk("mulh_rst_accepted", got, 1'b1);
    v0 = 0;
    tick();
    #2 rst = 1;
    #1;
    chk("async_rst_rsp_valid", rsp_valid, 1'b0);
    chk("async_rst_carry", carry_q, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 0;

    // both valid continuously: alternating grants starting with req0
    v0 = 1; v1 = 1; op0 = 4'd3; op1 = 4'd4;
    x0 = 32'hf0f0f0f0; y0 = 32'h0ff00ff0; x1 = 32'h12340000; y1 = 32'h00005678;
    nacc = 0;
    for (int n = 0; n < 60 && nacc < 4; n++) begin
      tick();
      if (last_hs) begin ids[nacc] = int'(last_hs_id); nacc++; end
    end
    chk("tie_accepts", nacc, 4);
    for (int i = 0; i < 4; i++) chk("tie_grant_id", ids[i], i % 2);

    // consumer stalls: response frozen, no requester accepted
    rr = 0;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin tick(); got = s_valid; end
    chk("stall_rsp_seen", got, 1'b1);
    hold_res = s_res; hold_id = s_id;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("stall_valid", s_valid, 1'b1);
      chk("stall_result", s_res, hold_res);
      chk("stall_id", s_id, hold_id);
      chk("stall_ready0", s_r0, 1'b0);
      chk("stall_ready1", s_r1, 1'b0);
    end
    rr = 1;
    tick();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      v0  = ($urandom_range(0, 2) != 0);
      v1  = ($urandom_range(0, 2) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      op0 = 4'($urandom_range(0, 15));
      op1 = 4'($urandom_range(0, 15));
      x0  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y0  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      x1  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      y1  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      tick();
    end
    v0 = 0; v1 = 0; rr = 1;
    for (int n = 0; n < 10; n++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
